// File: rtl/truth_table_checker_pkg.sv
// Shared types and constants for the exhaustive 4-input truth-table checker.
package truth_table_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int VEC_W   = 4;
    localparam int NUM_VEC = 16;

    // Equality-chain function: 0 only where no two adjacent inputs match (0101, 1010).
    localparam logic [NUM_VEC-1:0] GOLDEN_DEFAULT = 16'hFBDF;

endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// Per-vector settle counter: counts 0..SETTLE_CYCLES while enabled and pulses
// expired on the terminal count.
module settle_timer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    logic [7:0] cnt_q, cnt_d;

    assign expired = en && (cnt_q == 8'(SETTLE_CYCLES));

    always_comb begin
        cnt_d = cnt_q;
        if (clear || expired) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/truth_table_checker.sv
// Drives all 16 input vectors to an external 4-input function, samples its
// response after a settle interval and compares it against GOLDEN.
module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter int                  SETTLE_CYCLES = 4,
    parameter logic [NUM_VEC-1:0]  GOLDEN        = GOLDEN_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               f_in,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               d,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [NUM_VEC-1:0] captured,
    output logic [4:0]         mismatch_cnt,
    output logic [VEC_W-1:0]   first_fail_idx,
    output logic               fail_seen
);

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   idx_q, idx_d;
    logic [NUM_VEC-1:0] captured_q, captured_d;
    logic [4:0]         mismatch_cnt_q, mismatch_cnt_d;
    logic [VEC_W-1:0]   first_fail_idx_q, first_fail_idx_d;
    logic               fail_seen_q, fail_seen_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    logic start_acc;
    logic expired;

    assign start_acc = start && (state_q != RUN);

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start_acc),
        .en     (state_q == RUN),
        .expired(expired)
    );

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        captured_d       = captured_q;
        mismatch_cnt_d   = mismatch_cnt_q;
        first_fail_idx_d = first_fail_idx_q;
        fail_seen_d      = fail_seen_q;
        done_d           = done_q;
        pass_d           = pass_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d          = RUN;
                    idx_d            = '0;
                    captured_d       = '0;
                    mismatch_cnt_d   = '0;
                    first_fail_idx_d = '0;
                    fail_seen_d      = 1'b0;
                    done_d           = 1'b0;
                    pass_d           = 1'b0;
                end
            end
            RUN: begin
                if (expired) begin
                    captured_d[idx_q] = f_in;
                    if (f_in != GOLDEN[idx_q]) begin
                        mismatch_cnt_d = mismatch_cnt_q + 5'd1;
                        if (!fail_seen_q) begin
                            first_fail_idx_d = idx_q;
                            fail_seen_d      = 1'b1;
                        end
                    end
                    // Last vector: idx stays at 15 so a..d hold 4'b1111.
                    if (idx_q == 4'(NUM_VEC - 1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = (captured_d == GOLDEN);
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            idx_q            <= '0;
            captured_q       <= '0;
            mismatch_cnt_q   <= '0;
            first_fail_idx_q <= '0;
            fail_seen_q      <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            captured_q       <= captured_d;
            mismatch_cnt_q   <= mismatch_cnt_d;
            first_fail_idx_q <= first_fail_idx_d;
            fail_seen_q      <= fail_seen_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
        end
    end

    assign a              = idx_q[3];
    assign b              = idx_q[2];
    assign c              = idx_q[1];
    assign d              = idx_q[0];
    assign busy           = (state_q == RUN);
    assign done           = done_q;
    assign pass           = pass_q;
    assign captured       = captured_q;
    assign mismatch_cnt   = mismatch_cnt_q;
    assign first_fail_idx = first_fail_idx_q;
    assign fail_seen      = fail_seen_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench: two checker instances (settle 4 and settle 1) against a
// reference equality-chain function or tied-off responses.
module tb_truth_table_checker;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // dut0: SETTLE_CYCLES=4
    logic        start0;
    logic        f0;
    logic        a0, b0, c0, d0, busy0, done0, pass0, fs0;
    logic [15:0] cap0;
    logic [4:0]  mc0;
    logic [3:0]  ffi0;
    int          mode0;   // 0 = reference, 1 = tied 1, 2 = tied 0

    // dut1: SETTLE_CYCLES=1
    logic        start1;
    logic        f1;
    logic        a1, b1, c1, d1, busy1, done1, pass1, fs1;
    logic [15:0] cap1;
    logic [4:0]  mc1;
    logic [3:0]  ffi1;
    int          mode1;

    // Equality chain: 1 when any adjacent pair of inputs matches.
    assign f0 = (mode0 == 0) ? ((a0 == b0) || (b0 == c0) || (c0 == d0)) : (mode0 == 1);
    assign f1 = (mode1 == 0) ? ((a1 == b1) || (b1 == c1) || (c1 == d1)) : (mode1 == 1);

    truth_table_checker #(.SETTLE_CYCLES(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .f_in(f0),
        .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0), .pass(pass0),
        .captured(cap0), .mismatch_cnt(mc0), .first_fail_idx(ffi0), .fail_seen(fs0)
    );

    truth_table_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .f_in(f1),
        .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .pass(pass1),
        .captured(cap1), .mismatch_cnt(mc1), .first_fail_idx(ffi1), .fail_seen(fs1)
    );

    logic        sel;
    logic        s_busy, s_done, s_pass, s_fs;
    logic [15:0] s_cap;
    logic [4:0]  s_mc;
    logic [3:0]  s_ffi, s_abcd;
    always_comb begin
        s_busy = sel ? busy1 : busy0;
        s_done = sel ? done1 : done0;
        s_pass = sel ? pass1 : pass0;
        s_fs   = sel ? fs1   : fs0;
        s_cap  = sel ? cap1  : cap0;
        s_mc   = sel ? mc1   : mc0;
        s_ffi  = sel ? ffi1  : ffi0;
        s_abcd = sel ? {a1, b1, c1, d1} : {a0, b0, c0, d0};
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called away from a clock edge. Raises start, checks the cleared state after
    // the accepting edge, optionally re-pulses start mid-sweep, and returns the
    // number of edges from the accepting edge to the done edge.
    task automatic sweep(input int restart_at, output int n);
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        chk("start_busy", 32'(s_busy), 32'd1);
        chk("start_clear", {s_done, s_pass, s_fs, s_cap, s_mc, s_ffi}, 32'd0);
        n = 0;
        while (1) begin
            @(posedge clk); #1;
            n++;
            if (sel) start1 = 1'b0; else start0 = 1'b0;
            if (s_done) break;
            if (n == restart_at) begin
                if (sel) start1 = 1'b1; else start0 = 1'b1;
            end
            if (n > 2000) begin
                chk("sweep_timeout", 32'(n), 32'd0);
                break;
            end
        end
    endtask

    int n;

    initial begin
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
        mode0 = 0; mode1 = 0; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs0", {a0, b0, c0, d0, busy0, done0, pass0, fs0, cap0, mc0, ffi0}, 32'd0);
        chk("reset_outs1", {busy1, done1, pass1, cap1}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("no_implied_start", {busy0, done0, busy1, done1}, 32'd0);

        // Reference function, settle 4
        sweep(0, n);
        chk("ref_cycles", 32'(n), 32'd80);
        chk("ref_captured", 32'(s_cap), 32'hFBDF);
        chk("ref_pass", 32'(s_pass), 32'd1);
        chk("ref_mc", 32'(s_mc), 32'd0);
        chk("ref_fail_seen", 32'(s_fs), 32'd0);
        chk("ref_busy", 32'(s_busy), 32'd0);
        chk("ref_abcd_hold", 32'(s_abcd), 32'hF);
        repeat (3) @(posedge clk);
        #1;
        chk("ref_done_held", {s_done, s_pass, s_abcd}, 32'h3F);

        // f tied 1
        mode0 = 1;
        sweep(0, n);
        chk("t1_captured", 32'(s_cap), 32'hFFFF);
        chk("t1_mc", 32'(s_mc), 32'd2);
        chk("t1_ffi", 32'(s_ffi), 32'd5);
        chk("t1_fail_seen", 32'(s_fs), 32'd1);
        chk("t1_pass", 32'(s_pass), 32'd0);

        // f tied 0
        mode0 = 2;
        sweep(0, n);
        chk("t0_captured", 32'(s_cap), 32'h0000);
        chk("t0_mc", 32'(s_mc), 32'd14);
        chk("t0_ffi", 32'(s_ffi), 32'd0);
        chk("t0_fail_seen", 32'(s_fs), 32'd1);
        chk("t0_pass", 32'(s_pass), 32'd0);

        // start re-pulsed at cycle 30 is ignored
        mode0 = 0;
        sweep(30, n);
        chk("rs_cycles", 32'(n), 32'd80);
        chk("rs_captured", 32'(s_cap), 32'hFBDF);
        chk("rs_pass_mc", {s_pass, s_mc}, 32'h20);

        // Reset at cycle 40 of a tied-1 sweep (mismatch at vector 5 already seen)
        mode0 = 1;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("mid_partial", {busy0, fs0, mc0, ffi0, a0, b0, c0, d0}, {22'd0, 1'b1, 1'b1, 5'd1, 4'd5, 4'h8} >> 0);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outs", {a0, b0, c0, d0, busy0, done0, pass0, fs0, cap0, mc0, ffi0}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        mode0 = 0;
        @(posedge clk); #1;
        sweep(0, n);
        chk("post_reset_cycles", 32'(n), 32'd80);
        chk("post_reset_pass", {s_pass, s_cap}, {15'd0, 1'b1, 16'hFBDF});

        // settle 1: tied-1 sweep, then back-to-back reference sweep
        sel = 1'b1;
        mode1 = 1;
        sweep(0, n);
        chk("s1_first_cycles", 32'(n), 32'd32);
        chk("s1_first_res", {s_pass, s_mc, s_cap}, {11'd0, 1'b0, 5'd2, 16'hFFFF});
        mode1 = 0;
        sweep(0, n);
        chk("s1_second_cycles", 32'(n), 32'd32);
        chk("s1_second_cap", 32'(s_cap), 32'hFBDF);
        chk("s1_second_res", {s_pass, s_fs, s_mc}, 32'h40);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
